// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The master modport is the loader's view; slave is the environment's view.
interface program_loader_if #(
  parameter int ADDRESS_BITWIDTH = 16
);
  logic                        start;
  logic [7:0]                  byte_data;
  logic                        byte_valid;
  logic                        byte_ready;
  logic [ADDRESS_BITWIDTH-1:0] write_address;
  logic [31:0]                 write_data;
  logic                        write_enable;
  logic [31:0]                 word_count;
  logic                        busy;
  logic                        done;
  logic                        error;

  modport master (
    input  start, byte_data, byte_valid,
    output byte_ready, write_address, write_data, write_enable,
    output word_count, busy, done, error
  );

  modport slave (
    output start, byte_data, byte_valid,
    input  byte_ready, write_address, write_data, write_enable,
    input  word_count, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: assembles a little-endian {N, N words, XOR checksum}
// byte stream into 32-bit words and writes them to program memory.
module program_loader #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int BASE_ADDRESS     = 0
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_e;

  // Words that fit between BASE_ADDRESS and the top of the address space.
  localparam logic [32:0] CAPACITY =
    (33'd1 << (ADDRESS_BITWIDTH - 2)) - 33'(BASE_ADDRESS / 4);
  localparam logic [ADDRESS_BITWIDTH-1:0] BASE = ADDRESS_BITWIDTH'(BASE_ADDRESS);

  state_e                      state_q, state_d;
  logic [1:0]                  idx_q, idx_d;
  logic [23:0]                 asm_q, asm_d;
  logic [31:0]                 len_q, len_d;
  logic [31:0]                 acc_q, acc_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic                        we_q, we_d;
  logic [ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
  logic [31:0]                 data_q, data_d;

  logic        ready;
  logic        accept;
  logic        last;
  logic [31:0] word;

  assign ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept = bus.byte_valid && ready;
  assign last   = accept && (idx_q == 2'd3);
  assign word   = {bus.byte_data, asm_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    len_d   = len_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    // The 4th byte completes the word via 'word'; only bytes 0..2 are stored.
    if (accept) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    asm_d[7:0]   = bus.byte_data;
        2'd1:    asm_d[15:8]  = bus.byte_data;
        2'd2:    asm_d[23:16] = bus.byte_data;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_LEN;
          idx_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_LEN: begin
        if (last) begin
          len_d = word;
          if (word == 32'd0)                state_d = S_CSUM;
          else if ({1'b0, word} > CAPACITY) state_d = S_ERROR;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          we_d   = 1'b1;
          data_d = word;
          addr_d = BASE + {cnt_q[ADDRESS_BITWIDTH-3:0], 2'b00};
          cnt_d  = cnt_q + 32'd1;
          acc_d  = acc_q ^ word;
          if (cnt_q + 32'd1 == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (last) state_d = (word == acc_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready    = ready;
  assign bus.busy          = ready;
  assign bus.done          = (state_q == S_DONE);
  assign bus.error         = (state_q == S_ERROR);
  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
  assign bus.word_count    = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frame table, random frames against a
// frame-level reference model, and a reset-during-load sequence.
module tb_program_loader;
  localparam int AW   = 16;
  localparam int BASE = 0;
  localparam logic [63:0] CAP = (64'd1 << (AW - 2)) - 64'(BASE / 4);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.ADDRESS_BITWIDTH(AW)) bus ();

  program_loader #(.ADDRESS_BITWIDTH(AW), .BASE_ADDRESS(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];
  logic [31:0]   fw[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wr_addr.push_back(bus.write_address);
      wr_data.push_back(bus.write_data);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0, w1, w2;
    logic [31:0] csum;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    bit          spacing;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xor_words();
    logic [31:0] x = '0;
    foreach (fw[i]) x ^= fw[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    bit r;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      r = bus.byte_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (r) ok = 1'b1;
    end
    bus.byte_valid = 1'b0;
  endtask

  // Streams a frame built from n, fw and csum; a frame whose length exceeds
  // capacity is cut after the length field since the loader stops accepting.
  task automatic run_frame(input string tag, input logic [31:0] n, input logic [31:0] csum,
                           input bit gaps, input bit exp_done, input bit exp_err,
                           input int exp_wr, input bit spacing);
    logic [7:0] bytes[$];
    bit ok;
    int nw;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    if ({32'd0, n} <= CAP) begin
      foreach (fw[k]) for (int i = 0; i < 4; i++) bytes.push_back(fw[k][8*i +: 8]);
      for (int i = 0; i < 4; i++) bytes.push_back(csum[8*i +: 8]);
    end
    bus.start = 1'b1;
    ok = 1'b1;
    foreach (bytes[i]) begin
      send_byte(bytes[i], gaps, ok);
      if (!ok) begin
        check({tag, " byte handshake timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    check({tag, " done"},       64'(bus.done),       64'(exp_done));
    check({tag, " error"},      64'(bus.error),      64'(exp_err));
    check({tag, " busy"},       64'(bus.busy),       64'd0);
    check({tag, " byte_ready"}, 64'(bus.byte_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, " word_count"},   64'(bus.word_count), 64'(exp_wr));
    check({tag, " write count"},  64'(wr_addr.size()), 64'(exp_wr));
    nw = (wr_addr.size() < exp_wr) ? wr_addr.size() : exp_wr;
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr[i]), 64'(BASE + 4 * i));
      check($sformatf("%s data[%0d]", tag, i), 64'(wr_data[i]), 64'(fw[i]));
      if (spacing && i > 0)
        check($sformatf("%s spacing[%0d]", tag, i), 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},          64'(bus.busy),          64'd0);
    check({tag, " done"},          64'(bus.done),          64'd0);
    check({tag, " error"},         64'(bus.error),         64'd0);
    check({tag, " byte_ready"},    64'(bus.byte_ready),    64'd0);
    check({tag, " write_enable"},  64'(bus.write_enable),  64'd0);
    check({tag, " write_address"}, 64'(bus.write_address), 64'd0);
    check({tag, " write_data"},    64'(bus.write_data),    64'd0);
    check({tag, " word_count"},    64'(bus.word_count),    64'd0);
  endtask

  initial begin
    logic [31:0] n, csum;
    bit ok, good, gaps;
    int ewr;

    tbl[0] = '{32'd1, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[1] = '{32'd3, 32'h1, 32'h2, 32'h4, 32'h7, 1'b0, 1'b1, 1'b0, 3, 1'b1};
    tbl[2] = '{32'd3, 32'h1, 32'h2, 32'h4, 32'h6, 1'b0, 1'b0, 1'b1, 3, 1'b1};
    tbl[3] = '{32'h4001, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[4] = '{32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[5] = '{32'd1, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[v]) begin
      fw.delete();
      if ({32'd0, tbl[v].n} <= CAP) begin
        if (tbl[v].n > 0) fw.push_back(tbl[v].w0);
        if (tbl[v].n > 1) fw.push_back(tbl[v].w1);
        if (tbl[v].n > 2) fw.push_back(tbl[v].w2);
      end
      run_frame($sformatf("vec%0d", v), tbl[v].n, tbl[v].csum, tbl[v].gaps,
                tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_wr, tbl[v].spacing);
    end

    // Random frames against a frame-level model of the loader.
    for (int t = 0; t < 25; t++) begin
      n = ($urandom_range(0, 9) == 0) ? 32'h4001 + $urandom_range(0, 1000) : $urandom_range(0, 6);
      fw.delete();
      if ({32'd0, n} <= CAP) for (int i = 0; i < int'(n); i++) fw.push_back($urandom);
      csum = xor_words();
      if ($urandom_range(0, 2) == 0) csum ^= (32'd1 << $urandom_range(0, 31));
      gaps = 1'($urandom_range(0, 1));
      good = ({32'd0, n} <= CAP) && (csum == xor_words());
      ewr  = ({32'd0, n} <= CAP) ? int'(n) : 0;
      run_frame($sformatf("rand%0d", t), n, csum, gaps, good, !good, ewr, !gaps);
    end

    // Reset two bytes into the first data word, then reload from scratch.
    bus.start = 1'b1;
    ok = 1'b1;
    send_byte(8'h02, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h11, 1'b0, ok);
    send_byte(8'h22, 1'b0, ok);
    check("midload busy before reset", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midload reset");
    reset = 1'b0;
    @(posedge clk); #1;
    fw.delete();
    fw.push_back(32'hCAFEF00D);
    fw.push_back(32'h0BADBEEF);
    run_frame("reload", 32'd2, xor_words(), 1'b0, 1'b1, 1'b0, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program memory's write port: boot-time loader that takes a byte stream (from the UART receiver) and assembles little-endian 32-bit words.
- Drives write_address / write_data / write_enable of the program memory.
- Frame format: 4-byte word count N, then N data words, then a 4-byte XOR checksum word. All multi-byte fields are little-endian.
- Reports done/error so the core can be held in reset until the image is loaded.

Parameters:
- ADDRESS_BITWIDTH, 16, byte-address width of the program memory write port.
- BASE_ADDRESS, 0, byte address of the first loaded word; must be a multiple of 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load
- byte_data  input  8  incoming stream byte
- byte_valid  input  1  byte_data valid
- byte_ready  output  1  loader accepts byte this cycle
- write_address  output  ADDRESS_BITWIDTH  program memory byte write address
- write_data  output  32  assembled word
- write_enable  output  1  one-cycle write strobe
- word_count  output  32  number of data words written so far
- busy  output  1  load in progress
- done  output  1  sticky: load finished with a checksum match
- error  output  1  sticky: length overflow or checksum mismatch

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs are 0, and the state is IDLE. Reset takes priority in every state. A reset mid-load discards partial bytes and counters; memory contents already written are not rolled back.
- Byte acceptance: a byte is accepted only on a cycle where byte_valid && byte_ready.
  - byte_ready = 1 in LEN, DATA and CSUM; 0 in IDLE, DONE and ERROR.
  - A byte presented while byte_ready = 0 is not consumed; the sender must hold it.
- Word assembly: a 2-bit byte index collects bytes into bits [7:0], [15:8], [23:16], [31:24] in arrival order. The index resets to 0 on every state entry.
- State machine:
  - IDLE: start moves to LEN and clears done, error and word_count. If start and byte_valid occur in the same cycle, the byte is not accepted.
  - LEN: after the 4th byte, N is latched.
    - N = 0 goes to CSUM.
    - N > capacity goes to ERROR. Capacity = 2^(ADDRESS_BITWIDTH-2) - BASE_ADDRESS/4.
    - Otherwise goes to DATA.
  - DATA: on the 4th byte of each word:
    - In the following cycle, write_enable = 1 for exactly one cycle, with write_data = the assembled word and write_address = BASE_ADDRESS + 4*word_count (pre-increment value).
    - In that same cycle word_count increments and the running XOR accumulator (reset to 0 on LEN entry) absorbs the word.
    - After the Nth word, go to CSUM.
  - CSUM: after the 4th byte, compare it against the accumulator. Match goes to DONE; mismatch goes to ERROR.
  - DONE: done = 1. ERROR: error = 1. Both hold until start (which restarts a load, as from IDLE) or reset.
  - start in LEN, DATA or CSUM is ignored.
- busy = 1 in LEN, DATA and CSUM.
- write_enable is never asserted outside DATA-phase word completion. write_address and write_data hold their last values when write_enable = 0.
- Throughput: one byte per cycle is sustained; back-to-back words produce write_enable pulses 4 cycles apart.
- Address wrap is impossible by construction, because of the capacity check.

Test Plan:
- Reset, then start, then stream 01 00 00 00 | 78 56 34 12 | 78 56 34 12 → one write_enable pulse with address 0x0000 and data 0x12345678; word_count = 1; done = 1 and error = 0 after the last byte.
- N = 3 with words 0x00000001, 0x00000002, 0x00000004, checksum 0x00000007, one byte per cycle → writes to 0x0, 0x4, 0x8 exactly 4 cycles apart; done = 1.
- Same frame with checksum 0x00000006 → all 3 writes still occur, then error = 1 and done = 0; byte_ready = 0 afterwards.
- ADDRESS_BITWIDTH = 16, BASE_ADDRESS = 0, N = 0x00004001 → error = 1 immediately after the 4th length byte; no write_enable pulse ever occurs.
- N = 0 with checksum 00 00 00 00 → done = 1 with no writes. Separately, drop byte_valid randomly mid-word → data 0xDEADBEEF is still written correctly.
- Assert reset after 2 data bytes of word 1 → all outputs are 0 and the state is IDLE. A new start and full frame then loads correctly from address BASE_ADDRESS.
